// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART buffer transmitter.
// 8N1 framing: one start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_end is high combinationally on the last cycle of each bit.
// Restarts from 0 whenever clear is high; holds while enable is low.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end = enable && (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_streamer.sv
// Streams len bytes from an external 1-cycle-latency BRAM onto an 8N1 serial line.
// Two idle-high cycles of fetch overhead per byte; start is ignored while busy.
module uart_tx_streamer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ADDR_W       = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              done_q, done_d;

    logic bit_end;
    logic baud_en;
    logic last_byte;
    logic last_data_bit;
    logic last_stop_bit;
    logic unused_hi;

    // Only the low byte of each buffer word is payload.
    assign unused_hi = ^mem_rd[31:8];

    assign baud_en       = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign last_byte     = (cnt_q == ADDR_W'(1));
    assign last_data_bit = (bit_idx_q == 3'(DATA_BITS - 1));
    assign last_stop_bit = (bit_idx_q == 3'(STOP_BITS - 1));

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (CLK),
        .rst    (RST),
        .clear  (state_d != state_q),
        .enable (baud_en),
        .bit_end(bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (len != '0)) state_d = FETCH;
            FETCH:   state_d = LATCH;
            LATCH:   state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && last_data_bit) state_d = STOP;
            STOP:    if (bit_end && last_stop_bit) state_d = last_byte ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state_q != IDLE);
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shreg_q[bit_idx_q];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        ptr_d = base_addr;
                        cnt_d = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LATCH: begin
                shreg_d   = mem_rd[7:0];
                bit_idx_d = '0;
            end
            DATA: begin
                if (bit_end) bit_idx_d = bit_idx_q + 3'd1;
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop_bit) begin
                        bit_idx_d = '0;
                        cnt_d     = cnt_q - ADDR_W'(1);
                        ptr_d     = ptr_q + ADDR_W'(1);
                        done_d    = last_byte;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
        end
    end

    assign mem_addr = ptr_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Bench for uart_tx_streamer: per-cycle waveform model plus literal checks on key scenarios.
module tb_uart_tx_streamer;

    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [9:0]  len = '0;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rd = '0;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] mem [1024];

    uart_tx_streamer #(.CLKS_PER_BIT(CPB), .ADDR_W(10)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) mem_rd <= mem[mem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected line state for one cycle, derived from the frame format.
    typedef struct packed {
        logic       tx;
        logic       busy;
        logic       done;
        logic       achk;
        logic [9:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0, achk: 1'b0, addr: 10'd0};
    bit   chk_en = 1'b0;

    always @(posedge CLK) begin
        exp_t e;
        logic [9:0] a;
        logic [7:0] b;
        if (RST) begin
            exp_q.delete();
            cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0, achk: 1'b0, addr: 10'd0};
        end else begin
            if (exp_q.size() == 0 && start) begin
                for (int k = 0; k < int'(len); k++) begin
                    a = base_addr + 10'(k);
                    b = mem[a][7:0];
                    e = '{tx: 1'b1, busy: 1'b1, done: 1'b0, achk: 1'b1, addr: a};
                    exp_q.push_back(e);
                    e.achk = 1'b0;
                    exp_q.push_back(e);
                    e.tx = 1'b0;
                    for (int c = 0; c < CPB; c++) exp_q.push_back(e);
                    for (int i = 0; i < 8; i++) begin
                        e.tx = b[i];
                        for (int c = 0; c < CPB; c++) exp_q.push_back(e);
                    end
                    e.tx = 1'b1;
                    for (int c = 0; c < CPB; c++) exp_q.push_back(e);
                end
                exp_q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1, achk: 1'b0, addr: 10'd0});
            end
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            else cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0, achk: 1'b0, addr: 10'd0};
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("tx", 32'(tx), 32'(cur.tx));
            chk("busy", 32'(busy), 32'(cur.busy));
            chk("done", 32'(done), 32'(cur.done));
            if (cur.achk) chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
        end
    end

    // Observation of the current transfer for literal checks.
    int         busy_cnt = 0;
    int         done_cnt = 0;
    logic       tx_rec [64];
    logic [9:0] addr_seq[$];

    always @(negedge CLK) begin
        if (busy) begin
            if (busy_cnt < 64) tx_rec[busy_cnt] = tx;
            busy_cnt++;
            if (addr_seq.size() == 0 || addr_seq[$] != mem_addr) addr_seq.push_back(mem_addr);
        end
        if (done) done_cnt++;
    end

    task automatic clear_mon();
        busy_cnt = 0;
        done_cnt = 0;
        addr_seq.delete();
    endtask

    task automatic run(input logic [9:0] b, input logic [9:0] n);
        @(posedge CLK);
        #1;
        clear_mon();
        base_addr = b;
        len       = n;
        start     = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done_cnt > 0) break;
        end
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (4) @(negedge CLK);
    endtask

    function automatic logic [9:0] frame_bits();
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = tx_rec[2 + CPB * i + 1];
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h010] = 32'h0000_00A5;
        mem[10'h3FE] = 32'hABCD_EF12;
        mem[10'h3FF] = 32'h0000_0034;
        mem[10'h000] = 32'h5500_0056;
        mem[10'h020] = 32'h0000_003C;
        mem[10'h021] = 32'h0000_00C3;
        mem[10'h100] = 32'h0000_0000;
        mem[10'h030] = 32'h0000_005A;
        mem[10'h040] = 32'hFFFF_FF00;

        // Reset, with a start asserted alongside it that must lose.
        @(posedge CLK);
        chk_en = 1'b1;
        #1;
        start = 1'b1;
        len   = 10'd5;
        @(negedge CLK);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge CLK);
        #1;
        start = 1'b0;
        RST   = 1'b0;
        repeat (3) @(posedge CLK);

        // Single byte 0xA5.
        run(10'h010, 10'd1);
        wait_done(200);
        chk("a5_busy_cycles", 32'(busy_cnt), 32'd42);
        chk("a5_done_pulses", 32'(done_cnt), 32'd1);
        chk("a5_frame", 32'(frame_bits()), 32'(10'b11_0100_1010));

        // Three bytes across the address wrap.
        run(10'h3FE, 10'd3);
        wait_done(500);
        chk("wrap_done_pulses", 32'(done_cnt), 32'd1);
        chk("wrap_busy_cycles", 32'(busy_cnt), 32'd126);
        chk("wrap_addr_count", 32'(addr_seq.size()), 32'd3);
        if (addr_seq.size() == 3) begin
            chk("wrap_addr0", 32'(addr_seq[0]), 32'h3FE);
            chk("wrap_addr1", 32'(addr_seq[1]), 32'h3FF);
            chk("wrap_addr2", 32'(addr_seq[2]), 32'h000);
        end

        // Zero-length request.
        run(10'h055, 10'd0);
        wait_done(10);
        chk("len0_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("len0_done_pulses", 32'(done_cnt), 32'd1);

        // Second start during DATA must be ignored.
        run(10'h020, 10'd2);
        repeat (20) @(posedge CLK);
        #1;
        base_addr = 10'h100;
        len       = 10'd1;
        start     = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done(400);
        chk("ign_busy_cycles", 32'(busy_cnt), 32'd84);
        chk("ign_done_pulses", 32'(done_cnt), 32'd1);
        chk("ign_addr_count", 32'(addr_seq.size()), 32'd2);
        if (addr_seq.size() == 2) chk("ign_addr1", 32'(addr_seq[1]), 32'h021);

        // Reset in the middle of DATA.
        run(10'h030, 10'd1);
        repeat (20) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (60) @(negedge CLK);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Fresh transfer of 0x00 with upper word bits all ones.
        run(10'h040, 10'd1);
        wait_done(200);
        chk("zero_busy_cycles", 32'(busy_cnt), 32'd42);
        chk("zero_done_pulses", 32'(done_cnt), 32'd1);
        chk("zero_frame", 32'(frame_bits()), 32'(10'b10_0000_0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
